// File: rtl/snake_pkg.sv
// snake_pkg: shared grid geometry, tile codes, clear FSM states and tile RAM read tags
package snake_pkg;
   localparam int GRID_W = 40;
   localparam int GRID_H = 30;
   localparam int TILES = GRID_W * GRID_H;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 4;
   typedef enum logic [DATA_W-1:0] {
      TILE_EMPTY = 4'd0,
      TILE_SNAKE = 4'd1,
      TILE_FOOD  = 4'd2,
      TILE_WALL  = 4'd3
   } tile_e;
   typedef enum logic {OWN_SCAN, OWN_GL} owner_e;
   typedef enum logic [1:0] {CLR_IDLE, CLR_CLEAR, CLR_DONE} clr_state_e;
   typedef struct packed {
      logic   vld;
      owner_e own;
      logic   oor;
   } rd_tag_t;
endpackage

// File: rtl/tile_clear_seq.sv
// tile_clear_seq: walks every tile address once, issuing a clear write whenever the RAM slot is free
module tile_clear_seq #(
   parameter int ADDR_W = snake_pkg::ADDR_W,
   parameter int TILES  = snake_pkg::TILES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              slot_free_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o
);
   import snake_pkg::*;
   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   // state and address counter registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= CLR_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   // advance one tile per free slot; the last tile hands over to a one-cycle DONE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLR_IDLE: if (start_i) begin
            state_d = CLR_CLEAR;
            cnt_d   = '0;
         end
         CLR_CLEAR: if (slot_free_i) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(TILES - 1)) state_d = CLR_DONE;
         end
         default: state_d = CLR_IDLE;
      endcase
   end
   assign busy_o    = state_q == CLR_CLEAR;
   assign done_o    = state_q == CLR_DONE;
   assign wr_en_o   = busy_o & slot_free_i;
   assign wr_addr_o = cnt_q;
endmodule

// File: rtl/tile_ram_arbiter.sv
// tile_ram_arbiter: shares the single-port tile RAM between scanout, the clear sequencer and game logic
module tile_ram_arbiter #(
   parameter int                ADDR_W  = snake_pkg::ADDR_W,
   parameter int                DATA_W  = snake_pkg::DATA_W,
   parameter int                TILES   = snake_pkg::TILES,
   parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(snake_pkg::TILE_EMPTY)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_req,
   input  logic [ADDR_W-1:0] scan_addr,
   output logic              scan_valid,
   output logic [DATA_W-1:0] scan_data,
   input  logic              gl_req,
   input  logic              gl_we,
   input  logic [ADDR_W-1:0] gl_addr,
   input  logic [DATA_W-1:0] gl_wdata,
   output logic              gl_gnt,
   output logic              gl_rvalid,
   output logic [DATA_W-1:0] gl_rdata,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   import snake_pkg::*;
   logic              clr_wr_en, sel_any, sel_we, sel_oor;
   logic [ADDR_W-1:0] clr_addr, sel_addr, ram_addr_q;
   logic [DATA_W-1:0] sel_wdata, ram_wdata_q, rdata_m;
   logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
   rd_tag_t           tag_d, tag1_q, tag2_q;

   tile_clear_seq #(.ADDR_W(ADDR_W), .TILES(TILES)) u_clear (
      .clk         (clk),
      .rst         (rst),
      .start_i     (clr_start),
      .slot_free_i (~scan_req),
      .busy_o      (clr_busy),
      .done_o      (clr_done),
      .wr_en_o     (clr_wr_en),
      .wr_addr_o   (clr_addr)
   );

   assign gl_gnt  = gl_req & ~scan_req & ~clr_busy & ~clr_done;
   assign sel_any = scan_req | clr_wr_en | gl_gnt;

   // pick this cycle's winner and form the next RAM command plus its read tag
   always_comb begin
      sel_addr  = scan_req ? scan_addr : clr_wr_en ? clr_addr : gl_addr;
      sel_we    = ~scan_req & (clr_wr_en | gl_we);
      sel_wdata = clr_wr_en ? CLR_VAL : gl_wdata;
      sel_oor   = sel_addr >= ADDR_W'(TILES);
      ram_en_d  = sel_any & ~sel_oor;
      ram_we_d  = ram_en_d & sel_we;
      tag_d.vld = sel_any & ~sel_we;
      tag_d.own = scan_req ? OWN_SCAN : OWN_GL;
      tag_d.oor = sel_oor;
   end

   // RAM command registers and the two-stage read tag pipe aligned to RAM latency
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         tag1_q      <= '0;
         tag2_q      <= '0;
      end else begin
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= sel_addr;
         ram_wdata_q <= sel_wdata;
         tag1_q      <= tag_d;
         tag2_q      <= tag1_q;
      end

   assign ram_en     = ram_en_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign rdata_m    = tag2_q.oor ? '0 : ram_rdata;
   assign scan_valid = tag2_q.vld & (tag2_q.own == OWN_SCAN);
   assign gl_rvalid  = tag2_q.vld & (tag2_q.own == OWN_GL);
   assign scan_data  = scan_valid ? rdata_m : '0;
   assign gl_rdata   = gl_rvalid ? rdata_m : '0;
endmodule

// File: tb/tb_tile_ram_arbiter.sv
// tb_tile_ram_arbiter: directed checks of the tile RAM arbiter against a behavioural sync RAM
module tb_tile_ram_arbiter;
   logic        clk = 0, rst = 1;
   logic        scan_req = 0, gl_req = 0, gl_we = 0, clr_start = 0;
   logic [10:0] scan_addr = 0, gl_addr = 0, ram_addr;
   logic [3:0]  gl_wdata = 0, scan_data, gl_rdata, ram_wdata, ram_rdata = 0;
   logic        scan_valid, gl_gnt, gl_rvalid, clr_busy, clr_done, ram_en, ram_we;
   logic [3:0]  mem [0:2047];
   int          wr_cnt = 0, wr_oor = 0;
   int          n_chk = 0, n_fail = 0;
   int          cyc, w0, err;
   logic        h1, h2;

   tile_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .scan_req(scan_req), .scan_addr(scan_addr), .scan_valid(scan_valid), .scan_data(scan_data),
      .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
      .gl_gnt(gl_gnt), .gl_rvalid(gl_rvalid), .gl_rdata(gl_rdata),
      .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // single-port sync-read RAM with one cycle of read latency
   always @(posedge clk)
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else ram_rdata <= mem[ram_addr];
      end

   // write traffic counters
   always @(posedge clk)
      if (ram_en && ram_we) begin
         wr_cnt <= wr_cnt + 1;
         if (ram_addr >= 11'd1200) wr_oor <= wr_oor + 1;
      end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gl_write(input logic [10:0] a, input logic [3:0] d);
      gl_req = 1; gl_we = 1; gl_addr = a; gl_wdata = d;
      tick();
      gl_req = 0; gl_we = 0;
   endtask

   initial begin
      #2;
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_valids", {scan_valid, gl_rvalid}, 0);
      check("rst_clr", {clr_busy, clr_done}, 0);
      check("rst_gnt", gl_gnt, 0);
      tick(); tick();
      rst = 0;
      tick();

      // scan read
      gl_write(11'd5, 4'd2);
      gl_write(11'd7, 4'd1);
      tick();
      scan_req = 1; scan_addr = 11'd5;
      tick();
      scan_req = 0;
      check("scan_ram_en", ram_en, 1);
      check("scan_ram_addr", ram_addr, 5);
      check("scan_valid_n1", scan_valid, 0);
      tick();
      check("scan_valid_n2", scan_valid, 1);
      check("scan_data_n2", scan_data, 2);
      tick();

      // collision: scan wins, gl granted next cycle
      scan_req = 1; scan_addr = 11'd5; gl_req = 1; gl_we = 0; gl_addr = 11'd7;
      #1 check("coll_gnt_n", gl_gnt, 0);
      tick();
      scan_req = 0;
      #1 check("coll_gnt_n1", gl_gnt, 1);
      tick();
      gl_req = 0;
      check("coll_scan_valid_n2", scan_valid, 1);
      check("coll_gl_rvalid_n2", gl_rvalid, 0);
      tick();
      check("coll_gl_rvalid_n3", gl_rvalid, 1);
      check("coll_gl_rdata_n3", gl_rdata, 1);
      check("coll_scan_valid_n3", scan_valid, 0);

      // gl write then read back; out-of-range write and read
      gl_write(11'd10, 4'd3);
      check("glw_ram_we", {ram_en, ram_we}, 2'b11);
      gl_req = 1; gl_we = 0; gl_addr = 11'd10;
      tick();
      gl_req = 0;
      tick();
      check("glr_rvalid", gl_rvalid, 1);
      check("glr_rdata", gl_rdata, 3);
      gl_req = 1; gl_we = 1; gl_addr = 11'd1200; gl_wdata = 4'd5;
      #1 check("oorw_gnt", gl_gnt, 1);
      tick();
      gl_req = 0; gl_we = 0;
      check("oorw_ram_en", ram_en, 0);
      gl_req = 1; gl_addr = 11'd1200;
      #1 check("oorr_gnt", gl_gnt, 1);
      tick();
      gl_req = 0;
      check("oorr_ram_en", ram_en, 0);
      tick();
      check("oorr_rvalid", gl_rvalid, 1);
      check("oorr_rdata", gl_rdata, 0);

      // clear without scan traffic; gl held off, restart pulse ignored
      for (int i = 0; i < 1200; i++) gl_write(11'(i), 4'd3);
      tick();
      w0 = wr_cnt;
      clr_start = 1;
      #1 check("clr_busy_pre", clr_busy, 0);
      tick();
      clr_start = 0;
      cyc = 1;
      check("clr_busy_run", clr_busy, 1);
      gl_req = 1; gl_we = 0; gl_addr = 11'd20;
      err = 0;
      while (!clr_done && cyc < 3000) begin
         clr_start = (cyc == 100);
         #1 if (gl_gnt) err++;
         tick();
         cyc++;
      end
      clr_start = 0;
      check("clr_done_cycle", cyc, 1201);
      check("clr_busy_done", clr_busy, 0);
      #1 check("clr_gnt_done", gl_gnt, 0);
      check("clr_gnt_during", err, 0);
      tick();
      check("clr_done_pulse", clr_done, 0);
      check("clr_gnt_idle", gl_gnt, 1);
      gl_req = 0;
      tick(); tick();
      check("clr_writes", wr_cnt - w0, 1200);
      err = 0;
      for (int i = 0; i < 1200; i++) if (mem[i] !== 4'd0) err++;
      check("clr_nonzero", err, 0);
      check("oor_writes", wr_oor, 0);

      // clear with scan every other cycle
      w0 = wr_cnt;
      clr_start = 1;
      tick();
      clr_start = 0;
      cyc = 1; h1 = 0; h2 = 0; err = 0;
      while (!clr_done && cyc < 6000) begin
         scan_req = cyc[0]; scan_addr = 11'd5;
         #1 if (scan_valid !== h2) err++;
         h2 = h1; h1 = scan_req;
         tick();
         cyc++;
      end
      scan_req = 0;
      check("clrs_done_cycle", cyc, 2401);
      check("clrs_scan_valid", err, 0);
      tick(); tick();
      check("clrs_writes", wr_cnt - w0, 1200);

      // reset in the middle of a clear with a scan read in flight
      gl_write(11'd599, 4'd3);
      gl_write(11'd600, 4'd3);
      tick();
      clr_start = 1;
      tick();
      clr_start = 0;
      repeat (600) tick();
      scan_req = 1; scan_addr = 11'd5;
      tick();
      scan_req = 0;
      check("mid_busy", clr_busy, 1);
      check("mid_ram_en", ram_en, 1);
      rst = 1;
      #1;
      check("mid_rst_ram_en", ram_en, 0);
      check("mid_rst_busy", clr_busy, 0);
      check("mid_rst_valid", scan_valid, 0);
      tick(); tick();
      rst = 0;
      err = 0;
      repeat (4) begin
         tick();
         if (scan_valid || clr_done || clr_busy) err++;
      end
      check("post_rst_quiet", err, 0);
      check("part_mem599", mem[599], 0);
      check("part_mem600", mem[600], 3);
      gl_req = 1; gl_we = 0; gl_addr = 11'd600;
      #1 check("post_rst_gnt", gl_gnt, 1);
      tick();
      gl_req = 0;
      tick();
      check("post_rst_rdata", gl_rdata, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
